// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data memory between the CPU MEM stage and an
// external loader/debug master, with a req/ack memory handshake and a watchdog.
module dmem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wdata_i,
   output logic [DATA_W-1:0] cpu_rdata_o,
   output logic              cpu_ack_o,
   output logic              cpu_stall_o,
   input  logic              ext_req_i,
   input  logic              ext_we_i,
   input  logic [ADDR_W-1:0] ext_addr_i,
   input  logic [DATA_W-1:0] ext_wdata_i,
   output logic [DATA_W-1:0] ext_rdata_o,
   output logic              ext_ack_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ack_i,
   output logic              err_o,
   output logic              err_owner_o
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              state_r;
   state_t              next_state_s;
   logic [CNT_W-1:0]    cnt_r;
   logic                owner_r;       // 0 = CPU, 1 = EXT
   logic                last_owner_r;
   logic                grant_s;
   logic                grant_ext_s;
   logic                mem_done_s;
   logic                timeout_s;
   logic                mem_req_r;
   logic                mem_we_r;
   logic [ADDR_W-1:0]   mem_addr_r;
   logic [DATA_W-1:0]   mem_wdata_r;
   logic [DATA_W-1:0]   cpu_rdata_r;
   logic [DATA_W-1:0]   ext_rdata_r;
   logic                cpu_ack_r;
   logic                ext_ack_r;
   logic                err_r;
   logic                err_owner_r;

   // Next-state, round-robin grant and BUSY-exit decode.
   always_comb begin
      next_state_s = state_r;
      grant_s      = 1'b0;
      grant_ext_s  = 1'b0;
      mem_done_s   = 1'b0;
      timeout_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (cpu_req_i && ext_req_i) begin
               grant_s      = 1'b1;
               grant_ext_s  = ~last_owner_r;
               next_state_s = ST_BUSY;
            end else if (cpu_req_i) begin
               grant_s      = 1'b1;
               grant_ext_s  = 1'b0;
               next_state_s = ST_BUSY;
            end else if (ext_req_i) begin
               grant_s      = 1'b1;
               grant_ext_s  = 1'b1;
               next_state_s = ST_BUSY;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (mem_ack_i) begin
               mem_done_s   = 1'b1;
               next_state_s = ST_DONE;
            end else if (cnt_r == TIMEOUT_C) begin
               timeout_s    = 1'b1;
               next_state_s = ST_DONE;
            end else begin
               next_state_s = ST_BUSY;
            end
         end
         ST_DONE: begin
            next_state_s = ST_IDLE;
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // State, ownership and watchdog counter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r      <= ST_IDLE;
         cnt_r        <= '0;
         owner_r      <= 1'b0;
         last_owner_r <= 1'b1;   // EXT, so the CPU wins the first tie
      end else begin
         state_r <= next_state_s;
         if (grant_s) begin
            owner_r      <= grant_ext_s;
            last_owner_r <= grant_ext_s;
            cnt_r        <= CNT_ONE_C;
         end else if ((state_r == ST_BUSY) && !mem_done_s && !timeout_s) begin
            cnt_r <= cnt_r + CNT_ONE_C;
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   // Latched request copy driving the memory side; we/req only live in BUSY.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= '0;
      end else if (grant_s) begin
         mem_req_r   <= 1'b1;
         mem_we_r    <= grant_ext_s ? ext_we_i    : cpu_we_i;
         mem_addr_r  <= grant_ext_s ? ext_addr_i  : cpu_addr_i;
         mem_wdata_r <= grant_ext_s ? ext_wdata_i : cpu_wdata_i;
      end else if (mem_done_s || timeout_s) begin
         mem_req_r <= 1'b0;
         mem_we_r  <= 1'b0;
      end else begin
         mem_req_r <= mem_req_r;
         mem_we_r  <= mem_we_r;
      end
   end

   // Completion: owner ack pulse, read data capture and sticky timeout error.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cpu_ack_r   <= 1'b0;
         ext_ack_r   <= 1'b0;
         cpu_rdata_r <= '0;
         ext_rdata_r <= '0;
         err_r       <= 1'b0;
         err_owner_r <= 1'b0;
      end else begin
         cpu_ack_r <= (mem_done_s | timeout_s) & ~owner_r;
         ext_ack_r <= (mem_done_s | timeout_s) & owner_r;
         if (timeout_s) begin
            err_r       <= 1'b1;
            err_owner_r <= owner_r;
            if (owner_r) begin
               ext_rdata_r <= '0;
            end else begin
               cpu_rdata_r <= '0;
            end
         end else if (mem_done_s && !mem_we_r) begin
            if (owner_r) begin
               ext_rdata_r <= mem_rdata_i;
            end else begin
               cpu_rdata_r <= mem_rdata_i;
            end
         end else begin
            cpu_rdata_r <= cpu_rdata_r;
         end
      end
   end

   assign cpu_rdata_o = cpu_rdata_r;
   assign ext_rdata_o = ext_rdata_r;
   assign cpu_ack_o   = cpu_ack_r;
   assign ext_ack_o   = ext_ack_r;
   assign cpu_stall_o = cpu_req_i & ~cpu_ack_r;
   assign mem_req_o   = mem_req_r;
   assign mem_we_o    = mem_we_r;
   assign mem_addr_o  = mem_addr_r;
   assign mem_wdata_o = mem_wdata_r;
   assign err_o       = err_r;
   assign err_owner_o = err_owner_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios push expected acks,
// a forked monitor pops and compares on every ack pulse.
module tb_dmem_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        cpu_req_i, cpu_we_i, ext_req_i, ext_we_i;
   logic [31:0] cpu_addr_i, cpu_wdata_i, ext_addr_i, ext_wdata_i;
   logic [31:0] cpu_rdata_o, ext_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic        cpu_ack_o, cpu_stall_o, ext_ack_o, mem_req_o, mem_we_o;
   logic        mem_ack_i, err_o, err_owner_o;

   logic        mem_auto;
   logic        auto_ack, man_ack;
   logic [31:0] auto_rdata, man_rdata;

   typedef struct {
      logic        port;
      logic [31:0] rdata;
   } exp_t;
   exp_t exp_q[$];

   int total = 0;
   int bad   = 0;

   assign mem_ack_i   = mem_auto ? auto_ack   : man_ack;
   assign mem_rdata_i = mem_auto ? auto_rdata : man_rdata;

   always #5 clk_i = ~clk_i;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
      .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_ack_o(cpu_ack_o),
      .cpu_stall_o(cpu_stall_o),
      .ext_req_i(ext_req_i), .ext_we_i(ext_we_i), .ext_addr_i(ext_addr_i),
      .ext_wdata_i(ext_wdata_i), .ext_rdata_o(ext_rdata_o), .ext_ack_o(ext_ack_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
      .err_o(err_o), .err_owner_o(err_owner_o)
   );

   function automatic logic [31:0] mem_model(input logic [31:0] addr);
      return addr ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push(input logic port, input logic [31:0] rdata);
      exp_t e;
      e.port  = port;
      e.rdata = rdata;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      cpu_req_i = 1'b0; ext_req_i = 1'b0;
      man_ack = 1'b0;
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1;
      cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = 32'd0; cpu_wdata_i = 32'd0;
      ext_req_i = 1'b0; ext_we_i = 1'b0; ext_addr_i = 32'd0; ext_wdata_i = 32'd0;
      mem_auto = 1'b0; auto_ack = 1'b0; man_ack = 1'b0;
      auto_rdata = 32'd0; man_rdata = 32'd0;

      fork
         // monitor: compare every ack pulse against the scoreboard
         forever begin
            @(negedge clk_i);
            if (!rst_i) begin
               chk("dual_ack", {31'd0, cpu_ack_o & ext_ack_o}, 32'd0);
               if (cpu_ack_o || ext_ack_o) begin
                  total++;
                  if (exp_q.size() == 0) begin
                     bad++;
                     $display("FAIL unexpected_ack: got cpu=%b ext=%b expected none at %0t",
                              cpu_ack_o, ext_ack_o, $time);
                  end else begin
                     exp_t e;
                     e = exp_q.pop_front();
                     chk("ack_port", {31'd0, ext_ack_o}, {31'd0, e.port});
                     chk("ack_rdata", ext_ack_o ? ext_rdata_o : cpu_rdata_o, e.rdata);
                  end
               end
            end
         end
         // auto memory responder, zero wait states
         forever begin
            @(posedge clk_i);
            #1;
            if (mem_req_o && !auto_ack) begin
               auto_ack   = 1'b1;
               auto_rdata = mem_model(mem_addr_o);
            end else begin
               auto_ack = 1'b0;
            end
         end
      join_none

      // reset state
      do_reset();
      chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
      chk("rst_acks", {30'd0, cpu_ack_o, ext_ack_o}, 32'd0);
      chk("rst_err", {30'd0, err_o, err_owner_o}, 32'd0);
      chk("rst_cpu_rdata", cpu_rdata_o, 32'd0);
      chk("rst_mem_addr", mem_addr_o, 32'd0);

      // 1: CPU read, zero-wait memory
      cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h10;
      push(1'b0, 32'hDEAD_BEEF);
      #1;
      chk("t1_stall_c0", {31'd0, cpu_stall_o}, 32'd1);
      chk("t1_memreq_c0", {31'd0, mem_req_o}, 32'd0);
      tick();
      chk("t1_memreq_c1", {31'd0, mem_req_o}, 32'd1);
      chk("t1_addr_c1", mem_addr_o, 32'h10);
      chk("t1_stall_c1", {31'd0, cpu_stall_o}, 32'd1);
      man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
      tick();
      man_ack = 1'b0; man_rdata = 32'h0;
      chk("t1_ack_c2", {31'd0, cpu_ack_o}, 32'd1);
      chk("t1_stall_c2", {31'd0, cpu_stall_o}, 32'd0);
      chk("t1_memreq_c2", {31'd0, mem_req_o}, 32'd0);
      cpu_req_i = 1'b0;
      tick();
      chk("t1_ack_c3", {31'd0, cpu_ack_o}, 32'd0);

      // 2: simultaneous requests after reset alternate CPU, EXT, ...
      do_reset();
      mem_auto = 1'b1;
      for (int k = 0; k < 6; k++) begin
         push(k[0], mem_model(k[0] ? 32'h200 : 32'h100));
      end
      cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h100;
      ext_req_i = 1'b1; ext_we_i = 1'b0; ext_addr_i = 32'h200;
      begin
         int n;
         int last_i;
         n = 0;
         last_i = -1;
         for (int i = 1; i <= 60; i++) begin
            tick();
            if (cpu_ack_o || ext_ack_o) begin
               n++;
               if (n == 6) begin
                  cpu_req_i = 1'b0; ext_req_i = 1'b0;
                  last_i = i;
                  break;
               end
            end
         end
         chk("t2_ack_count", n, 32'd6);
         chk("t2_sixth_ack_cycle", last_i, 32'd17);
      end
      tick();
      mem_auto = 1'b0;
      tick();

      // 3: EXT write with three wait cycles, ext_rdata_o must hold
      push(1'b1, mem_model(32'h200));
      ext_req_i = 1'b1; ext_we_i = 1'b1; ext_addr_i = 32'h20; ext_wdata_i = 32'h1234;
      tick();
      ext_we_i = 1'b0; ext_addr_i = 32'h0; ext_wdata_i = 32'h0;
      for (int k = 0; k < 4; k++) begin
         chk("t3_we_busy", {31'd0, mem_we_o}, 32'd1);
         chk("t3_addr_busy", mem_addr_o, 32'h20);
         chk("t3_wdata_busy", mem_wdata_o, 32'h1234);
         chk("t3_ack_busy", {31'd0, ext_ack_o}, 32'd0);
         if (k == 3) begin
            man_ack = 1'b1; man_rdata = 32'hFACE_FACE;
         end
         tick();
      end
      man_ack = 1'b0;
      ext_req_i = 1'b0;
      chk("t3_ack", {31'd0, ext_ack_o}, 32'd1);
      chk("t3_we_done", {31'd0, mem_we_o}, 32'd0);
      tick();
      chk("t3_ack_once", {31'd0, ext_ack_o}, 32'd0);

      // 4: CPU read never acknowledged -> watchdog abort after 16 BUSY cycles
      push(1'b0, 32'h0);
      cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h40;
      tick();
      for (int k = 1; k <= 16; k++) begin
         chk("t4_memreq_busy", {31'd0, mem_req_o}, 32'd1);
         chk("t4_err_busy", {31'd0, err_o}, 32'd0);
         tick();
      end
      cpu_req_i = 1'b0;
      chk("t4_ack", {31'd0, cpu_ack_o}, 32'd1);
      chk("t4_err", {31'd0, err_o}, 32'd1);
      chk("t4_err_owner", {31'd0, err_owner_o}, 32'd0);
      chk("t4_memreq_done", {31'd0, mem_req_o}, 32'd0);
      for (int k = 0; k < 4; k++) tick();
      chk("t4_err_sticky", {31'd0, err_o}, 32'd1);

      // 5: reset in the 2nd BUSY cycle of an EXT read
      do_reset();
      chk("t5_err_cleared", {31'd0, err_o}, 32'd0);
      ext_req_i = 1'b1; ext_we_i = 1'b0; ext_addr_i = 32'h30;
      tick();
      tick();
      chk("t5_memreq_busy2", {31'd0, mem_req_o}, 32'd1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      ext_req_i = 1'b0;
      chk("t5_memreq_after_rst", {31'd0, mem_req_o}, 32'd0);
      chk("t5_no_ack", {31'd0, ext_ack_o}, 32'd0);
      man_ack = 1'b1; man_rdata = 32'h5555_AAAA;
      tick();
      man_ack = 1'b0;
      chk("t5_late_ack_ignored", {31'd0, ext_ack_o}, 32'd0);
      chk("t5_rdata_kept", ext_rdata_o, 32'd0);
      chk("t5_memreq_idle", {31'd0, mem_req_o}, 32'd0);

      // 6: stray mem_ack_i in IDLE and DONE
      man_ack = 1'b1; man_rdata = 32'hFFFF_FFFF;
      tick();
      man_ack = 1'b0;
      chk("t6_idle_rdata", cpu_rdata_o, 32'd0);
      chk("t6_idle_memreq", {31'd0, mem_req_o}, 32'd0);
      push(1'b0, 32'h0BAD_F00D);
      cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h50;
      tick();
      man_ack = 1'b1; man_rdata = 32'h0BAD_F00D;
      tick();
      cpu_req_i = 1'b0;
      man_rdata = 32'h1111_1111;
      chk("t6_ack", {31'd0, cpu_ack_o}, 32'd1);
      tick();
      man_ack = 1'b0;
      chk("t6_done_noack", {31'd0, cpu_ack_o}, 32'd0);
      chk("t6_done_rdata", cpu_rdata_o, 32'h0BAD_F00D);
      chk("t6_ext_rdata", ext_rdata_o, 32'd0);
      chk("t6_memreq", {31'd0, mem_req_o}, 32'd0);
      tick();
      tick();

      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the pipeline MEM stage (CPU port) and an external loader/debug master (EXT port).
- Latches the winning request and drives a req/ack memory handshake with variable latency.
- Returns read data and a one-cycle ack to the owner, and generates the pipeline stall.
- A watchdog aborts any access the memory never acknowledges, so the pipeline cannot hang.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 16, max BUSY cycles without mem_ack_i before abort (>=2)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous reset, active-high
cpu_req_i  in  1  CPU access request; held with stable addr/we/wdata until cpu_ack_o
cpu_we_i  in  1  1=write, 0=read
cpu_addr_i  in  ADDR_W  CPU address
cpu_wdata_i  in  DATA_W  CPU write data
cpu_rdata_o  out  DATA_W  CPU read data, valid when cpu_ack_o
cpu_ack_o  out  1  one-cycle completion pulse
cpu_stall_o  out  1  freeze IF/ID/EX/MEM; = cpu_req_i & ~cpu_ack_o (combinational)
ext_req_i  in  1  EXT request, same rules as CPU
ext_we_i  in  1  EXT write enable
ext_addr_i  in  ADDR_W  EXT address
ext_wdata_i  in  DATA_W  EXT write data
ext_rdata_o  out  DATA_W  EXT read data
ext_ack_o  out  1  EXT completion pulse
mem_req_o  out  1  memory request, high throughout BUSY
mem_we_o  out  1  memory write enable, 0 outside BUSY
mem_addr_o  out  ADDR_W  latched address
mem_wdata_o  out  DATA_W  latched write data
mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i
mem_ack_i  in  1  memory completion, honoured only in BUSY
err_o  out  1  sticky timeout flag
err_owner_o  out  1  owner of the last timed-out access (0=CPU, 1=EXT)

Behaviour:
- State machine: IDLE, BUSY, DONE. Registered state, counter, last_owner, owner, latched addr/we/wdata, rdata registers, ack registers.
- Reset values:
  - state=IDLE; last_owner=EXT, so CPU wins the first tie.
  - All acks, mem_req_o, mem_we_o, err_o and err_owner_o = 0.
  - cpu_rdata_o, ext_rdata_o, mem_addr_o and mem_wdata_o = 0.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requesting: grant the port that is not last_owner (round-robin).
  - On grant: latch owner and that port's addr/we/wdata, set last_owner=owner, counter=1, go to BUSY.
- BUSY:
  - mem_req_o=1; mem_we_o/addr/wdata come from the latch.
  - On mem_ack_i:
    - For a read, load the owner's rdata register from mem_rdata_i; for a write, leave rdata unchanged.
    - Set the owner's ack for the next cycle and go to DONE.
  - Else if counter==TIMEOUT: set err_o=1, err_owner_o=owner, owner rdata=0, owner ack next cycle, go to DONE.
  - Else counter+1.
- DONE:
  - Owner ack=1 for exactly this cycle; mem_req_o=0; no arbitration.
  - Next state is IDLE; requests are re-sampled there.
  - A requester may keep req high after ack to issue a back-to-back transaction.
- Latency: zero-wait memory (mem_ack_i in the first BUSY cycle) gives req sampled cycle 0, mem_req_o cycle 1, ack cycle 2, next grant sampled cycle 3. Each extra memory wait cycle adds one.
- Other rules:
  - Never both acks in the same cycle; at most one access outstanding.
  - mem_ack_i in IDLE or DONE is ignored.
  - Requester inputs are don't-care after the grant edge (latched copy used).
  - err_o is cleared only by rst_i.
  - Reset mid-BUSY: next edge returns to IDLE with mem_req_o=0 and no ack issued; the aborted access is lost.

Test Plan:
- Reset, then CPU read addr 0x10, mem acks first BUSY cycle with 0xDEADBEEF -> mem_req_o high cycle 1 only; cpu_ack_o=1 cycle 2 with cpu_rdata_o=0xDEADBEEF; cpu_stall_o=1 cycles 0-1, 0 cycle 2.
- CPU and EXT both request in the same cycle after reset, 1-cycle memory -> CPU served first, EXT granted at the next IDLE. Continuous requests alternate CPU, EXT, CPU…
- EXT write addr 0x20 data 0x1234, memory acks after 3 wait cycles -> mem_we_o=1 and mem_addr_o=0x20 for 4 BUSY cycles; ext_ack_o one cycle; ext_rdata_o unchanged.
- CPU read with mem_ack_i never asserted, TIMEOUT=16 -> BUSY 16 cycles, then err_o=1, err_owner_o=0, cpu_rdata_o=0, cpu_ack_o pulse. err_o stays high until rst_i.
- rst_i asserted during the 2nd BUSY cycle of an EXT read -> next cycle mem_req_o=0, state IDLE, no ext_ack_o. mem_ack_i arriving 1 cycle later is ignored.
- mem_ack_i pulsed during IDLE and DONE -> no ack outputs and no rdata change.
